// File: rtl/uart_lite_pkg.sv
// Shared definitions for the AXI UART Lite masters: register map, STAT bit
// positions, AXI response codes and the RX reader state encoding.
package uart_lite_pkg;

  localparam logic [3:0] UART_RX_FIFO_ADDR = 4'h0;
  localparam logic [3:0] UART_STAT_ADDR    = 4'h8;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_OVERRUN  = 5;
  localparam int unsigned STAT_FRAME    = 6;
  localparam int unsigned STAT_PARITY   = 7;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_POLL_AR = 3'd0,
    ST_POLL_R  = 3'd1,
    ST_RX_AR   = 3'd2,
    ST_RX_R    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } rx_state_t;

  // Line error flags as reported on the line_err port: {frame, overrun, parity}.
  function automatic logic [2:0] stat_line_err(input logic [7:0] stat);
    return {stat[STAT_FRAME], stat[STAT_OVERRUN], stat[STAT_PARITY]};
  endfunction

endpackage

// File: rtl/uart_poll_timer.sv
// Loadable down-counter pacing STAT polls; done is high while the count is zero.
module uart_poll_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/axi_uart_rx_reader.sv
// AXI4-Lite read master draining the UART Lite RX FIFO onto a valid/ready byte stream.
// Define UART_RX_LINE_ERR_EN to accumulate STAT frame/overrun/parity bits into line_err.
module axi_uart_rx_reader
  import uart_lite_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 16,
  parameter logic [3:0]  STAT_ADDR = UART_STAT_ADDR,
  parameter logic [3:0]  RX_ADDR   = UART_RX_FIFO_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] araddr,
  output logic       arvalid,
  input  logic       arready,
  input  logic [7:0] rdata,
  input  logic [1:0] rresp,
  input  logic       rvalid,
  output logic       rready,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       bus_err,
  output logic [2:0] line_err
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  rx_state_t  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       bus_err_q, bus_err_d;
  logic       tmr_load, tmr_count, tmr_done;

  uart_poll_timer #(
    .WIDTH (GAP_W)
  ) u_poll_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bus_err_d = bus_err_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    unique case (state_q)
      ST_POLL_AR: begin
        if (arready) state_d = ST_POLL_R;
      end
      ST_POLL_R: begin
        if (rvalid) begin
          if (rresp != AXI_RESP_OKAY) begin
            bus_err_d = 1'b1;
            state_d   = ST_WAIT;
            tmr_load  = 1'b1;
          end else if (rdata[STAT_RX_VALID]) begin
            state_d = ST_RX_AR;
          end else begin
            state_d  = ST_WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      ST_RX_AR: begin
        if (arready) state_d = ST_RX_R;
      end
      ST_RX_R: begin
        if (rvalid) begin
          // A failed RX read has already popped the byte in the core; it is lost.
          if (rresp == AXI_RESP_OKAY) begin
            data_d  = rdata;
            state_d = ST_HOLD;
          end else begin
            bus_err_d = 1'b1;
            state_d   = ST_POLL_AR;
          end
        end
      end
      ST_HOLD: begin
        if (ready) state_d = ST_POLL_AR;
      end
      ST_WAIT: begin
        tmr_count = 1'b1;
        if (tmr_done) state_d = ST_POLL_AR;
      end
      default: state_d = ST_POLL_AR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_POLL_AR;
      data_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
    end
  end

  // The reset state is an address phase, so the AR channel is masked while rst is held.
  always_comb begin
    arvalid = 1'b0;
    araddr  = '0;
    if (!rst) begin
      if (state_q == ST_POLL_AR) begin
        arvalid = 1'b1;
        araddr  = STAT_ADDR;
      end else if (state_q == ST_RX_AR) begin
        arvalid = 1'b1;
        araddr  = RX_ADDR;
      end
    end
  end

  assign rready  = (state_q == ST_POLL_R) || (state_q == ST_RX_R);
  assign valid   = (state_q == ST_HOLD);
  assign data    = data_q;
  assign bus_err = bus_err_q;

`ifdef UART_RX_LINE_ERR_EN
  logic [2:0] line_err_q, line_err_d;

  always_comb begin
    line_err_d = line_err_q;
    if ((state_q == ST_POLL_R) && rvalid && (rresp == AXI_RESP_OKAY)) begin
      line_err_d = line_err_q | stat_line_err(rdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_err_q <= '0;
    end else begin
      line_err_q <= line_err_d;
    end
  end

  assign line_err = line_err_q;
`else
  assign line_err = 3'b000;
`endif

endmodule

// File: tb/tb_axi_uart_rx_reader.sv
// Self-checking bench: behavioural UART Lite slave with a byte source array, stream
// scoreboard, and per-scenario tasks for latency, poll gap, hold, AR stall and errors.
module tb_axi_uart_rx_reader;

  localparam int         GAP    = 6;
  localparam logic [3:0] STAT_A = 4'h8;
  localparam logic [3:0] RX_A   = 4'h0;
`ifdef UART_RX_LINE_ERR_EN
  localparam logic [2:0] EXP_LINE_ERR = 3'b010;
`else
  localparam logic [2:0] EXP_LINE_ERR = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] araddr;
  logic       arvalid;
  logic       arready;
  logic [7:0] rdata;
  logic [1:0] rresp;
  logic       rvalid;
  logic       rready;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       bus_err;
  logic [2:0] line_err;

  axi_uart_rx_reader #(
    .POLL_GAP  (GAP),
    .STAT_ADDR (STAT_A),
    .RX_ADDR   (RX_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .bus_err  (bus_err),
    .line_err (line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Stimulus owned by the test tasks.
  logic [7:0] src_mem [0:1023];
  int         src_wr      = 0;
  int         err_req     = 0;
  int         ar_delay_cfg = 0;
  bit         rand_mode   = 1'b0;
  logic [7:0] stat_bits   = 8'h00;

  // State owned by the slave/monitor process.
  int         src_rd = 0;
  int         err_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         pend, inj;
  logic [3:0] pend_addr;
  int         ar_cnt, r_cnt, rnd_ar, rnd_r, cur_ar_delay;
  bit         s_arvalid, s_rready, s_valid;
  logic [3:0] s_araddr;
  logic [7:0] s_data;
  int n_ar_start = 0, n_ar_hs = 0, n_rx_hs = 0, n_empty_polls = 0, n_rx_err = 0;
  int n_valid_rise = 0, proto_viol = 0;
  int last_ar_start_cyc, last_stat_start_cyc, last_empty_rbeat_cyc, last_rx_err_cyc;
  int last_valid_rise_cyc, last_ar_len;
  logic [3:0] last_ar_start_addr;

  // Slave and stream monitor: samples just after each falling edge, so the values
  // seen are the ones the DUT saw at the preceding rising edge.
  initial begin : slave_model
    arready = 1'b0; rvalid = 1'b0; rdata = 8'h00; rresp = 2'b00;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; pend = 1'b0; ar_cnt = 0; r_cnt = 0;
        s_arvalid = 1'b0; s_araddr = 4'h0; s_rready = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      end else begin
        if (rvalid && s_rready) begin
          if (pend_addr == STAT_A) begin
            if (rresp == 2'b00 && rdata[0] == 1'b0) begin
              n_empty_polls++; last_empty_rbeat_cyc = cyc - 1;
            end
          end else if (rresp != 2'b00) begin
            n_rx_err++; last_rx_err_cyc = cyc - 1;
          end
          pend = 1'b0; rvalid = 1'b0;
        end
        if (s_arvalid && arready) begin
          n_ar_hs++; last_ar_len = ar_cnt + 1;
          if (s_araddr == RX_A) n_rx_hs++;
          pend = 1'b1; pend_addr = s_araddr; ar_cnt = 0; r_cnt = 0;
          rnd_ar = $urandom_range(0, 3); rnd_r = $urandom_range(0, 2);
        end else if (s_arvalid) begin
          ar_cnt++;
          if (!arvalid || araddr !== s_araddr) proto_viol++;
        end
        if (s_valid && ready) got_q.push_back(s_data);
        else if (s_valid && (!valid || data !== s_data)) proto_viol++;
        if (arvalid && pend) proto_viol++;
        if (arvalid && !s_arvalid) begin
          n_ar_start++; last_ar_start_cyc = cyc; last_ar_start_addr = araddr;
          if (araddr == STAT_A) last_stat_start_cyc = cyc;
        end
        if (valid && !s_valid) begin
          n_valid_rise++; last_valid_rise_cyc = cyc;
        end
        s_arvalid = arvalid; s_araddr = araddr; s_rready = rready;
        s_valid = valid; s_data = data;
        cur_ar_delay = rand_mode ? rnd_ar : ar_delay_cfg;
        arready = arvalid && !pend && (ar_cnt >= cur_ar_delay);
        if (pend && !rvalid) begin
          if (r_cnt >= (rand_mode ? rnd_r : 0)) begin
            rvalid = 1'b1;
            if (pend_addr == STAT_A) begin
              rdata = (stat_bits & 8'hFE) | {7'b0, (src_rd != src_wr)};
              rresp = 2'b00;
            end else begin
              if (src_rd != src_wr) begin
                rdata = src_mem[src_rd]; src_rd++;
              end else begin
                rdata = 8'h00;
              end
              inj = (err_done < err_req) || (rand_mode && $urandom_range(0, 7) == 0);
              if (err_done < err_req) err_done++;
              rresp = inj ? 2'b10 : 2'b00;
              if (!inj) exp_q.push_back(rdata);
            end
          end else begin
            r_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_mem[src_wr] = b;
    src_wr++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (arvalid !== 1'b0 || araddr !== 4'h0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ar got arvalid=%b araddr=%h rready=%b exp 0/0/0", arvalid, araddr, rready);
    end
    checks++;
    if (valid !== 1'b0 || data !== 8'h00 || bus_err !== 1'b0 || line_err !== 3'b000) begin
      errors++;
      $display("FAIL reset_stream got valid=%b data=%h bus_err=%b line_err=%b exp all 0",
               valid, data, bus_err, line_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (arvalid !== 1'b1 || araddr !== STAT_A) begin
      errors++;
      $display("FAIL reset_first_poll got arvalid=%b araddr=%h exp 1/%h", arvalid, araddr, STAT_A);
    end
  endtask

  task automatic test_latency();
    int n0, k, gb;
    ready = 1'b1;
    gb = got_q.size();
    n0 = n_valid_rise;
    push_byte(8'h5A);
    k = 0;
    while (n_valid_rise == n0 && k < 200) begin tick(); k++; end
    checks++;
    if (n_valid_rise == n0) begin
      errors++; $display("FAIL latency_timeout got no valid exp valid within 200 cycles");
    end else begin
      checks++;
      if (data !== 8'h5A) begin
        errors++; $display("FAIL latency_data got=%h exp=5a", data);
      end
      checks++;
      if (last_valid_rise_cyc - last_stat_start_cyc != 4) begin
        errors++;
        $display("FAIL latency_cycles got=%0d exp=4", last_valid_rise_cyc - last_stat_start_cyc);
      end
    end
    repeat (2) tick();
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 8'h5A) begin
      errors++; $display("FAIL latency_stream got count=%0d exp count=%0d of 5a", got_q.size() - gb, 1);
    end
  endtask

  task automatic test_poll_gap();
    int e0, a0, rx0, k, r;
    ready = 1'b1;
    for (int it = 0; it < 2; it++) begin
      e0 = n_empty_polls;
      k = 0;
      while (n_empty_polls == e0 && k < 200) begin tick(); k++; end
      r = last_empty_rbeat_cyc;
      a0 = n_ar_start;
      rx0 = n_rx_hs;
      k = 0;
      while (n_ar_start == a0 && k < 200) begin tick(); k++; end
      checks++;
      if (n_ar_start == a0 || last_ar_start_cyc - r - 1 != GAP || last_ar_start_addr !== STAT_A) begin
        errors++;
        $display("FAIL poll_gap_%0d got idle=%0d addr=%h exp idle=%0d addr=%h",
                 it, last_ar_start_cyc - r - 1, last_ar_start_addr, GAP, STAT_A);
      end
      checks++;
      if (n_rx_hs != rx0) begin
        errors++; $display("FAIL poll_gap_no_rx got rx_reads=%0d exp=0", n_rx_hs - rx0);
      end
    end
  endtask

  task automatic test_hold();
    int n0, k, gb, bad;
    tick();
    ready = 1'b0;
    gb = got_q.size();
    n0 = n_valid_rise;
    push_byte(8'h11);
    push_byte(8'h22);
    k = 0;
    while (n_valid_rise == n0 && k < 200) begin tick(); k++; end
    checks++;
    if (n_valid_rise == n0) begin
      errors++; $display("FAIL hold_timeout got no valid exp valid within 200 cycles");
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid !== 1'b1 || data !== 8'h11 || arvalid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable got %0d bad cycles exp 0 (valid=1 data=11 arvalid=0)", bad);
    end
    ready = 1'b1;
    k = 0;
    while (got_q.size() < gb + 2 && k < 200) begin tick(); k++; end
    checks++;
    if (got_q.size() != gb + 2) begin
      errors++; $display("FAIL hold_count got=%0d exp=2", got_q.size() - gb);
    end else begin
      checks++;
      if (got_q[gb] !== 8'h11 || got_q[gb+1] !== 8'h22) begin
        errors++; $display("FAIL hold_order got=%h,%h exp=11,22", got_q[gb], got_q[gb+1]);
      end
    end
  endtask

  task automatic test_ar_delay();
    int k, gb, v0;
    ready = 1'b1;
    ar_delay_cfg = 3;
    gb = got_q.size();
    v0 = proto_viol;
    push_byte(8'hC3);
    k = 0;
    while (got_q.size() == gb && k < 300) begin tick(); k++; end
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 8'hC3) begin
      errors++; $display("FAIL ar_delay_data got count=%0d exp one byte c3", got_q.size() - gb);
    end
    checks++;
    if (last_ar_len != 4) begin
      errors++; $display("FAIL ar_delay_len got=%0d exp=4 cycles of arvalid", last_ar_len);
    end
    checks++;
    if (proto_viol != v0) begin
      errors++; $display("FAIL ar_delay_stable got %0d violations exp 0", proto_viol - v0);
    end
    ar_delay_cfg = 0;
  endtask

  task automatic test_line_err();
    int k, gb;
    ready = 1'b1;
    gb = got_q.size();
    stat_bits = 8'h20;
    push_byte(8'h77);
    k = 0;
    while (got_q.size() == gb && k < 200) begin tick(); k++; end
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 8'h77) begin
      errors++; $display("FAIL line_err_data got count=%0d exp one byte 77", got_q.size() - gb);
    end
    checks++;
    if (line_err !== EXP_LINE_ERR) begin
      errors++; $display("FAIL line_err got=%b exp=%b", line_err, EXP_LINE_ERR);
    end
    stat_bits = 8'h00;
  endtask

  task automatic test_bus_err();
    int k, gb, e0, v0, r;
    ready = 1'b1;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++; $display("FAIL bus_err_clean got=%b exp=0", bus_err);
    end
    gb = got_q.size();
    e0 = n_rx_err;
    v0 = n_valid_rise;
    err_req++;
    push_byte(8'hE7);
    k = 0;
    while (n_rx_err == e0 && k < 200) begin tick(); k++; end
    r = last_rx_err_cyc;
    checks++;
    if (n_rx_err == e0 || last_ar_start_cyc != r + 1 || last_ar_start_addr !== STAT_A) begin
      errors++;
      $display("FAIL bus_err_resume got ar after %0d cycles addr=%h exp 1 cycle addr=%h",
               last_ar_start_cyc - r, last_ar_start_addr, STAT_A);
    end
    repeat (3 * GAP) tick();
    checks++;
    if (bus_err !== 1'b1) begin
      errors++; $display("FAIL bus_err_flag got=%b exp=1", bus_err);
    end
    checks++;
    if (n_valid_rise != v0 || got_q.size() != gb) begin
      errors++; $display("FAIL bus_err_dropped got %0d bytes exp 0", got_q.size() - gb);
    end
    push_byte(8'h3C);
    k = 0;
    while (got_q.size() == gb && k < 200) begin tick(); k++; end
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 8'h3C || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL bus_err_after got count=%0d bus_err=%b exp one byte 3c, bus_err=1",
               got_q.size() - gb, bus_err);
    end
  endtask

  task automatic test_random();
    int k, gb, eb, n;
    gb = got_q.size();
    eb = exp_q.size();
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) push_byte(8'($urandom));
      tick();
    end
    rand_mode = 1'b0;
    ready = 1'b1;
    k = 0;
    while ((src_rd != src_wr || got_q.size() - gb != exp_q.size() - eb || valid) && k < 2000) begin
      tick(); k++;
    end
    n = exp_q.size() - eb;
    checks++;
    if (got_q.size() - gb != n) begin
      errors++; $display("FAIL random_count got=%0d exp=%0d", got_q.size() - gb, n);
    end
    for (int i = 0; i < n && gb + i < got_q.size(); i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin
        errors++; $display("FAIL random_byte_%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, gb;
    ready = 1'b1;
    ar_delay_cfg = 50;
    repeat (GAP + 4) tick();
    push_byte(8'h99);
    repeat (GAP + 4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (arvalid !== 1'b0 || araddr !== 4'h0 || rready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bus got arvalid=%b araddr=%h rready=%b valid=%b exp all 0",
               arvalid, araddr, rready, valid);
    end
    checks++;
    if (data !== 8'h00 || bus_err !== 1'b0 || line_err !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_state got data=%h bus_err=%b line_err=%b exp 0/0/0", data, bus_err, line_err);
    end
    repeat (2) tick();
    ar_delay_cfg = 0;
    gb = got_q.size();
    rst = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== STAT_A) begin
      errors++; $display("FAIL reset_mid_restart got arvalid=%b araddr=%h exp 1/%h", arvalid, araddr, STAT_A);
    end
    k = 0;
    while (got_q.size() == gb && k < 200) begin tick(); k++; end
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 8'h99) begin
      errors++; $display("FAIL reset_mid_byte got count=%0d exp one byte 99", got_q.size() - gb);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got simulation still running exp finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_latency();
    test_poll_gap();
    test_hold();
    test_ar_delay();
    test_line_err();
    test_bus_err();
    test_random();
    test_reset_mid();
    checks++;
    if (proto_viol != 0) begin
      errors++; $display("FAIL protocol got %0d violations exp 0", proto_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
